// File: rtl/trdemu_trap_if.sv
// Signal bundle between the port decoder / CPU side and the VG93 trap sequencer.
// master = the decoder and NMI logic driving accesses, slave = trdemu_trap.
interface trdemu_trap_if;
  logic       vg_rdwr_fclk;
  logic [1:0] vg_reg;
  logic       vg_wr;
  logic [7:0] vg_wdata;
  logic [1:0] drv_sel;
  logic [3:0] fdd_mask;
  logic       dos;
  logic       romnram;
  logic       nmi_ack;
  logic       clr_nmi;
  logic       clr_stat;
  logic       nmi_req;
  logic       in_trdemu;
  logic [1:0] trap_reg;
  logic       trap_wr;
  logic [7:0] trap_wdata;
  logic [1:0] trap_drv;
  logic [7:0] stat;

  modport master (
    output vg_rdwr_fclk, vg_reg, vg_wr, vg_wdata, drv_sel, fdd_mask, dos, romnram,
           nmi_ack, clr_nmi, clr_stat,
    input  nmi_req, in_trdemu, trap_reg, trap_wr, trap_wdata, trap_drv, stat
  );

  modport slave (
    input  vg_rdwr_fclk, vg_reg, vg_wr, vg_wdata, drv_sel, fdd_mask, dos, romnram,
           nmi_ack, clr_nmi, clr_stat,
    output nmi_req, in_trdemu, trap_reg, trap_wr, trap_wdata, trap_drv, stat
  );
endinterface

// File: rtl/trdemu_trap.sv
// VG93 software-emulation trap sequencer: catches emulated-drive port accesses,
// raises NMI, maps the emulator page until the handler releases it via out (#BE),a.
module trdemu_trap #(
  parameter int ACK_TIMEOUT = 1024,
  parameter int HOLDOFF     = 16,
  parameter int CNT_W       = 12
) (
  input logic          fclk,
  input logic          rst_n,
  trdemu_trap_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVE, HOLD} state_t;

  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             trap_hit;
  logic             accept;
  logic             timeout_set;
  logic             overrun_set;

  logic             nmi_req_q;
  logic             in_trdemu_q;
  logic             busy_q;
  logic             err_timeout_q;
  logic             overrun_q;
  logic [1:0]       trap_reg_q;
  logic             trap_wr_q;
  logic [7:0]       trap_wdata_q;
  logic [1:0]       trap_drv_q;

  always_comb begin
    trap_hit    = bus.vg_rdwr_fclk & bus.fdd_mask[bus.drv_sel] & bus.dos & bus.romnram;
    state_nxt   = state;
    cnt_nxt     = cnt;
    accept      = 1'b0;
    timeout_set = 1'b0;
    overrun_set = trap_hit & (state != IDLE);

    case (state)
      IDLE: begin
        if (trap_hit) begin
          accept    = 1'b1;
          state_nxt = REQ;
          cnt_nxt   = '0;
        end
      end
      REQ: begin
        // Release beats acknowledge beats timeout when they coincide.
        if (bus.clr_nmi) begin
          state_nxt = (HOLDOFF == 0) ? IDLE : HOLD;
          cnt_nxt   = '0;
        end else if (bus.nmi_ack) begin
          state_nxt = SERVE;
        end else if (cnt == ACK_LAST) begin
          state_nxt   = IDLE;
          timeout_set = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      SERVE: begin
        if (bus.clr_nmi) begin
          state_nxt = (HOLDOFF == 0) ? IDLE : HOLD;
          cnt_nxt   = '0;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) state_nxt = IDLE;
        else                  cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so no input reaches a port combinationally.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      nmi_req_q     <= 1'b0;
      in_trdemu_q   <= 1'b0;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      overrun_q     <= 1'b0;
      trap_reg_q    <= '0;
      trap_wr_q     <= 1'b0;
      trap_wdata_q  <= '0;
      trap_drv_q    <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      nmi_req_q     <= (state_nxt == REQ);
      in_trdemu_q   <= (state_nxt == REQ) || (state_nxt == SERVE);
      busy_q        <= (state_nxt != IDLE);
      err_timeout_q <= timeout_set | (err_timeout_q & ~bus.clr_stat);
      overrun_q     <= overrun_set | (overrun_q & ~bus.clr_stat);
      if (accept) begin
        trap_reg_q   <= bus.vg_reg;
        trap_wr_q    <= bus.vg_wr;
        trap_wdata_q <= bus.vg_wdata;
        trap_drv_q   <= bus.drv_sel;
      end
    end
  end

  assign bus.nmi_req    = nmi_req_q;
  assign bus.in_trdemu  = in_trdemu_q;
  assign bus.trap_reg   = trap_reg_q;
  assign bus.trap_wr    = trap_wr_q;
  assign bus.trap_wdata = trap_wdata_q;
  assign bus.trap_drv   = trap_drv_q;
  assign bus.stat       = {busy_q, err_timeout_q, overrun_q, trap_wr_q, trap_drv_q, trap_reg_q};

endmodule

// File: tb/tb_trdemu_trap.sv
// Directed bench for trdemu_trap: qualification, NMI handshake, holdoff,
// timeout, overrun, priority and asynchronous reset behaviour.
module tb_trdemu_trap;

  logic fclk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  trdemu_trap_if bus ();

  trdemu_trap #(
    .ACK_TIMEOUT (1024),
    .HOLDOFF     (16),
    .CNT_W       (12)
  ) dut (
    .fclk  (fclk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 fclk = ~fclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge fclk);
    #1;
  endtask

  // One-cycle VG93 access strobe; outputs sampled 1 ns after the capturing edge.
  task automatic access(input logic [1:0] r, input logic w, input logic [7:0] d);
    bus.vg_reg       = r;
    bus.vg_wr        = w;
    bus.vg_wdata     = d;
    bus.vg_rdwr_fclk = 1'b1;
    step();
    bus.vg_rdwr_fclk = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.nmi_ack = 1'b1; step(); bus.nmi_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr_nmi = 1'b1; step(); bus.clr_nmi = 1'b0;
  endtask

  task automatic pulse_stat_clr();
    bus.clr_stat = 1'b1; step(); bus.clr_stat = 1'b0;
  endtask

  initial begin
    int n;
    bus.vg_rdwr_fclk = 1'b0;
    bus.vg_reg       = '0;
    bus.vg_wr        = 1'b0;
    bus.vg_wdata     = '0;
    bus.drv_sel      = '0;
    bus.fdd_mask     = '0;
    bus.dos          = 1'b0;
    bus.romnram      = 1'b0;
    bus.nmi_ack      = 1'b0;
    bus.clr_nmi      = 1'b0;
    bus.clr_stat     = 1'b0;

    repeat (3) step();
    check("rst_nmi_req", bus.nmi_req, 0);
    check("rst_in_trdemu", bus.in_trdemu, 0);
    check("rst_stat", bus.stat, 8'h00);
    @(negedge fclk);
    rst_n = 1'b1;
    step();
    check("post_rst_stat", bus.stat, 8'h00);
    check("post_rst_wdata", bus.trap_wdata, 8'h00);

    // Qualification: each missing condition blocks the trap.
    bus.fdd_mask = 4'b0010; bus.dos = 1'b1; bus.romnram = 1'b1; bus.drv_sel = 2'd0;
    access(2'd3, 1'b1, 8'hA5);
    check("nq_mask_nmi", bus.nmi_req, 0);
    check("nq_mask_stat", bus.stat, 8'h00);
    bus.drv_sel = 2'd1; bus.dos = 1'b0;
    access(2'd3, 1'b1, 8'hA5);
    check("nq_dos_nmi", bus.nmi_req, 0);
    check("nq_dos_stat", bus.stat, 8'h00);
    bus.dos = 1'b1; bus.romnram = 1'b0;
    access(2'd3, 1'b1, 8'hA5);
    check("nq_rom_nmi", bus.in_trdemu, 0);
    check("nq_rom_stat", bus.stat, 8'h00);
    bus.romnram = 1'b1;

    // Main trap: write #7F=#A5 on drive 1.
    access(2'd3, 1'b1, 8'hA5);
    check("trap_nmi_req", bus.nmi_req, 1);
    check("trap_in_trdemu", bus.in_trdemu, 1);
    check("trap_reg", bus.trap_reg, 2'd3);
    check("trap_wr", bus.trap_wr, 1);
    check("trap_wdata", bus.trap_wdata, 8'hA5);
    check("trap_drv", bus.trap_drv, 2'd1);
    check("trap_stat", bus.stat, 8'h97);
    repeat (3) step();
    check("req_hold_nmi", bus.nmi_req, 1);
    pulse_ack();
    check("ack_nmi_req", bus.nmi_req, 0);
    check("ack_in_trdemu", bus.in_trdemu, 1);

    // Overrun in SERVE must not disturb latches.
    access(2'd0, 1'b1, 8'h11);
    check("ovr_serve_reg", bus.trap_reg, 2'd3);
    check("ovr_serve_wdata", bus.trap_wdata, 8'hA5);
    check("ovr_serve_stat", bus.stat, 8'hB7);
    pulse_stat_clr();
    check("clr_stat_ovr", bus.stat, 8'h97);

    // Release at edge K, then holdoff of 16 cycles.
    pulse_clr();
    check("rel_in_trdemu", bus.in_trdemu, 0);
    check("rel_nmi_req", bus.nmi_req, 0);
    check("rel_busy", bus.stat[7], 1);
    access(2'd0, 1'b0, 8'h22);
    check("ovr_hold_wdata", bus.trap_wdata, 8'hA5);
    check("ovr_hold_flag", bus.stat[5], 1);
    repeat (14) step();
    check("hold_busy_k15", bus.stat[7], 1);
    step();
    check("hold_idle_k16", bus.stat, 8'h37);
    pulse_stat_clr();
    check("hold_clr_stat", bus.stat, 8'h17);

    // Timeout: nmi_req high for exactly 1024 cycles.
    access(2'd2, 1'b0, 8'h5A);
    check("to_trap_reg", bus.trap_reg, 2'd2);
    n = 0;
    while (bus.nmi_req && n < 2000) begin
      n++;
      step();
    end
    check("to_high_cycles", n, 1024);
    check("to_in_trdemu", bus.in_trdemu, 0);
    check("to_stat", bus.stat, 8'h46);
    pulse_stat_clr();
    check("to_clr_stat", bus.stat[6], 0);

    // Ack and release together in REQ: release wins.
    access(2'd1, 1'b1, 8'h3C);
    check("pri_req", bus.nmi_req, 1);
    bus.nmi_ack = 1'b1; bus.clr_nmi = 1'b1;
    step();
    bus.nmi_ack = 1'b0; bus.clr_nmi = 1'b0;
    check("pri_in_trdemu", bus.in_trdemu, 0);
    check("pri_busy", bus.stat[7], 1);
    // Overrun set and clr_stat in the same cycle: set wins.
    bus.clr_stat = 1'b1;
    access(2'd0, 1'b0, 8'h00);
    bus.clr_stat = 1'b0;
    check("set_wins_ovr", bus.stat[5], 1);
    check("set_wins_wdata", bus.trap_wdata, 8'h3C);
    n = 0;
    while (bus.stat[7] && n < 40) begin
      n++;
      step();
    end
    check("pri_idle_reached", bus.stat[7], 0);
    pulse_stat_clr();

    // Asynchronous reset while serving.
    access(2'd0, 1'b0, 8'h77);
    pulse_ack();
    check("svc_in_trdemu", bus.in_trdemu, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_nmi_req", bus.nmi_req, 0);
    check("arst_in_trdemu", bus.in_trdemu, 0);
    check("arst_stat", bus.stat, 8'h00);
    check("arst_wdata", bus.trap_wdata, 8'h00);
    @(negedge fclk);
    rst_n = 1'b1;
    step();
    access(2'd1, 1'b1, 8'hC3);
    check("fresh_nmi_req", bus.nmi_req, 1);
    check("fresh_wdata", bus.trap_wdata, 8'hC3);
    check("fresh_stat", bus.stat, 8'h95);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trdemu_trap.md
# trdemu_trap

Trap sequencer for the software VG93 emulation. Qualifies CPU accesses to VG93 ports on emulated drives, latches the access, raises an NMI request, maps emulator page #FE (`in_trdemu`) while the handler runs, and releases everything on `out (#BE),a`. It sits between the port decoder and the NMI/memory-map logic, next to the DOS-signal control.

## Interface
Parameters:
- ACK_TIMEOUT, 1024: fclk cycles allowed between NMI request and acknowledge; must be ≥2.
- HOLDOFF, 16: fclk cycles after release during which new traps are refused; 0 means no holdoff.
- CNT_W, 12: counter width; must hold max(ACK_TIMEOUT, HOLDOFF).

Ports:
- fclk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- vg_rdwr_fclk  in  1  one-cycle strobe: CPU access to a VG93 port
- vg_reg  in  2  port register index of the access (#1F=0, #3F=1, #5F=2, #7F=3)
- vg_wr  in  1  access direction, 1 = write
- vg_wdata  in  8  CPU write data, valid with strobe
- drv_sel  in  2  currently selected drive
- fdd_mask  in  4  per-drive emulation enable
- dos  in  1  DOS mode active
- romnram  in  1  ROM mapped at #0000
- nmi_ack  in  1  one-cycle strobe: opcode fetch from #0066
- clr_nmi  in  1  one-cycle strobe: `out (#BE),a`
- clr_stat  in  1  one-cycle strobe: clear sticky flags
- nmi_req  out  1  NMI request to CPU NMI driver
- in_trdemu  out  1  map emulator page #FE
- trap_reg  out  2  latched register index
- trap_wr  out  1  latched direction
- trap_wdata  out  8  latched write data
- trap_drv  out  2  latched drive
- stat  out  8  {busy, err_timeout, overrun, trap_wr, trap_drv[1:0], trap_reg[1:0]}

## Operation
- Trap condition T = vg_rdwr_fclk & fdd_mask[drv_sel] & dos & romnram.
- States: IDLE, REQ, SERVE, HOLD. Reset: IDLE; all outputs 0; latches 0; counter 0.
- IDLE: on T, latch vg_reg, vg_wr, vg_wdata, drv_sel into trap_* and go to REQ with counter cleared. clr_nmi and nmi_ack are ignored.
- REQ: nmi_req=1, in_trdemu=1. Counter increments each cycle.
  - clr_nmi: go to HOLD.
  - else nmi_ack: go to SERVE.
  - else if counter = ACK_TIMEOUT-1: go to IDLE and set err_timeout.
- SERVE: nmi_req=0, in_trdemu=1. Stays here until clr_nmi, then goes to HOLD. There is no timeout.
- HOLD: nmi_req=0, in_trdemu=0. Counter counts HOLDOFF cycles, then goes to IDLE. With HOLDOFF=0, clr_nmi goes straight to IDLE.
- A T occurring in REQ, SERVE or HOLD is dropped: latches are unchanged and overrun is set.
- Priority in REQ: clr_nmi > nmi_ack > timeout.
- busy = (state ≠ IDLE).
- Sticky flags (err_timeout, overrun) are cleared by clr_stat. If set and clear happen in the same cycle, set wins.
- trap_* outputs stay stable from capture until the next accepted trap.
- Async reset mid-operation: IDLE next edge-independent, nmi_req and in_trdemu drop immediately.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- T at edge N: trap_* valid and nmi_req/in_trdemu high after edge N. Latency is 1 cycle.
- nmi_ack at edge M: nmi_req low after M; in_trdemu stays high.
- clr_nmi at edge K: in_trdemu and nmi_req low after K. New traps are accepted from edge K+HOLDOFF+1.
- Timeout: nmi_req is high for exactly ACK_TIMEOUT cycles, then drops together with in_trdemu.

## Test plan
- Write #7F=#A5, drv_sel=1, fdd_mask=4'b0010, dos=1, romnram=1:
  - nmi_req and in_trdemu high 1 cycle later; trap_reg=3, trap_wr=1, trap_wdata=#A5, trap_drv=1.
  - nmi_ack drops nmi_req; clr_nmi drops in_trdemu.
  - After 16 cycles, busy=0.
- Access with fdd_mask[drv_sel]=0, or dos=0, or romnram=0 → no response; stat=0.
- nmi_ack withheld → nmi_req high for 1024 cycles, then IDLE with stat[6]=1. clr_stat → stat[6]=0.
- Second access during SERVE with vg_reg=0, vg_wdata=#11 → latches keep the first access; stat[5]=1. Access during HOLD → also dropped.
- nmi_ack and clr_nmi in the same REQ cycle → HOLD (clr_nmi wins). clr_stat and overrun in the same cycle → overrun stays 1.
- Assert rst_n low in SERVE → outputs 0 immediately. After release, a fresh trap is accepted normally.
